// File: rtl/d_mem_write_buffer.sv
// Posted write-back buffer between D-cache and data memory: evictions are acked at t+1 and drained in the background.
// Buffer hits answer at t+1; misses go to memory ahead of queued writes; a write to a full buffer stalls until a pop.
module d_mem_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 28,
    parameter int DW    = 128
) (
    input  logic          clk,
    input  logic          proc_reset_n,
    input  logic          cache_read,
    input  logic          cache_write,
    input  logic [AW-1:0] cache_addr,
    input  logic [DW-1:0] cache_wdata,
    output logic [DW-1:0] cache_rdata,
    output logic          cache_ready,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          wbuf_empty
);

    localparam int             PW       = $clog2(DEPTH);
    localparam logic [PW:0]    FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [AW-1:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic [PW:0]   w_count_nxt;

    logic          r_read_pend;
    logic [AW-1:0] r_read_addr;

    logic          r_cache_ready;
    logic [DW-1:0] r_cache_rdata;
    logic          r_mem_read;
    logic          r_mem_write;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_wbuf_empty;

    logic          w_fwd_hit;
    logic [PW-1:0] w_fwd_idx;
    logic          w_merge_hit;
    logic [PW-1:0] w_merge_idx;
    logic [PW-1:0] w_slot;

    logic          w_req_ok;
    logic          w_wr_req;
    logic          w_merge;
    logic          w_push;
    logic          w_rd_req;
    logic          w_rd_hit;
    logic          w_rd_miss;
    logic          w_pop;
    logic          w_rd_done;
    logic          w_launch_rd;
    logic          w_launch_wr;
    logic [DW-1:0] w_launch_wdata;

    // Scan oldest to newest so the last match is the newest copy of the line.
    // The head is excluded from merging only while its write is actually on the bus.
    always_comb begin
        w_fwd_hit   = 1'b0;
        w_fwd_idx   = '0;
        w_merge_hit = 1'b0;
        w_merge_idx = '0;
        w_slot      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_slot = r_head + PW'(i);
            if (((PW+1)'(i) < r_count) && (r_addr[w_slot] == cache_addr)) begin
                w_fwd_hit = 1'b1;
                w_fwd_idx = w_slot;
                if ((i != 0) || (r_state != S_WR)) begin
                    w_merge_hit = 1'b1;
                    w_merge_idx = w_slot;
                end
            end
        end
    end

    // A request is still high in its own ack cycle, so that cycle is ignored.
    assign w_req_ok    = !r_cache_ready;
    assign w_wr_req    = w_req_ok && cache_write;
    assign w_merge     = w_wr_req && w_merge_hit;
    assign w_push      = w_wr_req && !w_merge_hit && (r_count != FULL_CNT);
    assign w_rd_req    = w_req_ok && cache_read && !cache_write && !r_read_pend;
    assign w_rd_hit    = w_rd_req && w_fwd_hit;
    assign w_rd_miss   = w_rd_req && !w_fwd_hit;
    assign w_pop       = (r_state == S_WR) && mem_ready;
    assign w_rd_done   = (r_state == S_RD) && mem_ready;
    assign w_launch_rd = (r_state == S_IDLE) && r_read_pend;
    assign w_launch_wr = (r_state == S_IDLE) && !r_read_pend && (r_count != '0);

    // A merge into the head on the launch edge must reach memory, not the stale copy.
    assign w_launch_wdata = (w_merge && (w_merge_idx == r_head)) ? cache_wdata : r_data[r_head];

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + (PW+1)'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - (PW+1)'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_launch_rd) begin
                    w_state_nxt = S_RD;
                end else if (w_launch_wr) begin
                    w_state_nxt = S_WR;
                end
            end
            S_RD:    if (mem_ready) w_state_nxt = S_GAP;
            S_WR:    if (mem_ready) w_state_nxt = S_GAP;
            S_GAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_addr[r_tail] <= cache_addr;
                r_data[r_tail] <= cache_wdata;
            end
            if (w_merge) begin
                r_data[w_merge_idx] <= cache_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_state     <= S_IDLE;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_read_pend <= 1'b0;
            r_read_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            if (w_rd_miss) begin
                r_read_pend <= 1'b1;
                r_read_addr <= cache_addr;
            end else if (w_rd_done) begin
                r_read_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_wbuf_empty <= 1'b1;
        end else begin
            if (w_launch_rd) begin
                r_mem_read <= 1'b1;
                r_mem_addr <= r_read_addr;
            end else if (w_launch_wr) begin
                r_mem_write <= 1'b1;
                r_mem_addr  <= r_addr[r_head];
                r_mem_wdata <= w_launch_wdata;
            end
            if (w_rd_done) begin
                r_mem_read <= 1'b0;
            end
            if (w_pop) begin
                r_mem_write <= 1'b0;
            end
            r_wbuf_empty <= (w_count_nxt == '0) && (w_state_nxt != S_WR);
        end
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_cache_ready <= 1'b0;
            r_cache_rdata <= '0;
        end else begin
            r_cache_ready <= w_merge || w_push || w_rd_hit || w_rd_done;
            if (w_rd_hit) begin
                r_cache_rdata <= r_data[w_fwd_idx];
            end else if (w_rd_done) begin
                r_cache_rdata <= mem_rdata;
            end
        end
    end

    assign cache_ready = r_cache_ready;
    assign cache_rdata = r_cache_rdata;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign wbuf_empty  = r_wbuf_empty;

endmodule

// File: tb/tb_d_mem_write_buffer.sv
// Bench for d_mem_write_buffer: acts as the D-cache and as a slow data memory with programmable latency.
// Reads are checked against a coherent memory image; the drained memory contents against the same image.
module tb_d_mem_write_buffer;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk;
    logic          proc_reset_n;
    logic          cache_read;
    logic          cache_write;
    logic [AW-1:0] cache_addr;
    logic [DW-1:0] cache_wdata;
    logic [DW-1:0] cache_rdata;
    logic          cache_ready;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          wbuf_empty;

    d_mem_write_buffer #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .cache_read   (cache_read),
        .cache_write  (cache_write),
        .cache_addr   (cache_addr),
        .cache_wdata  (cache_wdata),
        .cache_rdata  (cache_rdata),
        .cache_ready  (cache_ready),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .wbuf_empty   (wbuf_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory contents as seen by memory itself, and as the cache should see it.
    logic [DW-1:0] mem_img   [logic [AW-1:0]];
    logic [DW-1:0] model_img [logic [AW-1:0]];

    bit            op_is_wr [$];
    logic [AW-1:0] op_addr  [$];
    logic [DW-1:0] op_data  [$];
    int            n_rd_ops    = 0;
    int            n_wr_ops    = 0;
    int            rd_ready_cyc = 0;
    bit            mem_stall   = 1'b0;
    int            mem_lat     = 1;

    function automatic logic [DW-1:0] init_pat(input logic [AW-1:0] a);
        return {a, 4'h9, a ^ 28'h5A5A5A5, 4'h3, ~a, 4'hC, a + 28'd7, 4'h1};
    endfunction

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return init_pat(a);
    endfunction

    function automatic logic [DW-1:0] model_val(input logic [AW-1:0] a);
        if (model_img.exists(a)) return model_img[a];
        return init_pat(a);
    endfunction

    function automatic logic [DW-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Memory responder: answers each request mem_lat cycles after it appears.
    initial begin
        int   wcnt;
        logic prev_rdy;
        wcnt      = 0;
        prev_rdy  = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (prev_rdy) chk("mem_gap", {mem_read, mem_write}, 0);
            mem_ready = 1'b0;
            if (!proc_reset_n || mem_stall || !(mem_read || mem_write)) begin
                wcnt = 0;
            end else if (wcnt >= mem_lat) begin
                mem_ready = 1'b1;
                wcnt      = 0;
                op_is_wr.push_back(!mem_read);
                op_addr.push_back(mem_addr);
                if (mem_read) begin
                    mem_rdata = mem_val(mem_addr);
                    op_data.push_back(mem_rdata);
                    n_rd_ops++;
                    rd_ready_cyc = cyc;
                end else begin
                    mem_img[mem_addr] = mem_wdata;
                    op_data.push_back(mem_wdata);
                    n_wr_ops++;
                end
            end else begin
                wcnt++;
            end
            prev_rdy = mem_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cache_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, output int lat);
        step();
        cache_addr  = a;
        cache_wdata = d;
        cache_write = 1'b1;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!cache_ready && lat < 400);
        cache_write = 1'b0;
        if (cache_ready) model_img[a] = d;
        else chk("wr_timeout", cache_ready, 1);
    endtask

    task automatic cache_rd(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
        step();
        cache_addr = a;
        cache_read = 1'b1;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!cache_ready && lat < 400);
        cache_read = 1'b0;
        d = cache_rdata;
        if (!cache_ready) chk("rd_timeout", cache_ready, 1);
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        while (!wbuf_empty && n < 400) begin
            step();
            n++;
        end
        chk(tag, wbuf_empty, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int            lat;
        int            base;
        int            cnt;
        int            seen;
        int            rdc;
        int            wrc;
        logic [DW-1:0] rd;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [DW-1:0] last_d;
        logic [AW-1:0] a;

        proc_reset_n = 1'b1;
        cache_read   = 1'b0;
        cache_write  = 1'b0;
        cache_addr   = '0;
        cache_wdata  = '0;
        #1 proc_reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cache_ready", cache_ready, 0);
        chk("rst_cache_rdata", cache_rdata, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_wbuf_empty", wbuf_empty, 1);
        proc_reset_n = 1'b1;
        step();

        // Single posted write drains to memory.
        mem_lat = 2;
        base = op_addr.size();
        d0 = rnd_line();
        cache_wr(28'h0000010, d0, lat);
        chk("wr_ack_lat", lat, 1);
        chk("wr_not_empty", wbuf_empty, 0);
        wait_empty("drain_single");
        chk("drain_cnt", op_addr.size() - base, 1);
        chk("drain_addr", op_addr[base], 28'h0000010);
        chk("drain_data", op_data[base], d0);

        // Read hits the in-flight head: forwarded, no memory read.
        mem_stall = 1'b1;
        rdc = n_rd_ops;
        d0 = rnd_line();
        cache_wr(28'h0000010, d0, lat);
        repeat (2) step();
        chk("fwd_inflight", mem_write, 1);
        cache_rd(28'h0000010, rd, lat);
        chk("fwd_lat", lat, 1);
        chk("fwd_data", rd, d0);
        chk("fwd_no_memrd", n_rd_ops - rdc, 0);
        mem_stall = 1'b0;
        wait_empty("drain_fwd");

        // Merge of a queued (not in-flight) entry: one memory write, newest data.
        mem_stall = 1'b1;
        base = op_addr.size();
        d0 = rnd_line();
        d1 = rnd_line();
        cache_wr(28'h0000020, rnd_line(), lat);
        cache_wr(28'h0000030, d0, lat);
        cache_wr(28'h0000030, d1, lat);
        chk("merge_ack_lat", lat, 1);
        mem_stall = 1'b0;
        wait_empty("drain_merge");
        cnt = 0;
        last_d = '0;
        for (int i = base; i < op_addr.size(); i++) begin
            if (op_is_wr[i] && op_addr[i] == 28'h0000030) begin
                cnt++;
                last_d = op_data[i];
            end
        end
        chk("merge_wr_cnt", cnt, 1);
        chk("merge_wr_data", last_d, d1);
        chk("merge_total", op_addr.size() - base, 2);

        // Full buffer: fifth write waits for the first pop, then acks two cycles after mem_ready.
        mem_stall = 1'b1;
        base = op_addr.size();
        for (int i = 0; i < 4; i++) begin
            cache_wr(28'h0000100 + 28'(i), rnd_line(), lat);
            chk("fill_ack_lat", lat, 1);
        end
        step();
        d0 = rnd_line();
        cache_addr  = 28'h0000104;
        cache_wdata = d0;
        cache_write = 1'b1;
        seen = 0;
        repeat (5) begin
            step();
            if (cache_ready) seen++;
        end
        chk("full_no_ack", seen, 0);
        mem_lat   = 0;
        mem_stall = 1'b0;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!cache_ready && cnt < 50);
        cache_write = 1'b0;
        chk("full_ack_lat", cnt, 2);
        if (cache_ready) model_img[28'h0000104] = d0;
        wait_empty("drain_full");
        for (int i = 0; i < 5; i++) begin
            chk("full_order", op_addr[base + i], 28'h0000100 + 28'(i));
        end

        // Read miss overtakes a queued write but not the one in flight.
        mem_stall = 1'b1;
        mem_lat   = 3;
        base = op_addr.size();
        cache_wr(28'h0000040, rnd_line(), lat);
        cache_wr(28'h0000050, rnd_line(), lat);
        step();
        cache_addr = 28'h0000060;
        cache_read = 1'b1;
        repeat (2) step();
        mem_stall = 1'b0;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!cache_ready && cnt < 100);
        cache_read = 1'b0;
        chk("miss_ready", cache_ready, 1);
        chk("miss_ready_delay", cyc - rd_ready_cyc, 1);
        chk("miss_data", cache_rdata, model_val(28'h0000060));
        wait_empty("drain_prio");
        chk("prio_op0", {op_is_wr[base], op_addr[base]}, {1'b1, 28'h0000040});
        chk("prio_op1", {op_is_wr[base + 1], op_addr[base + 1]}, {1'b0, 28'h0000060});
        chk("prio_op2", {op_is_wr[base + 2], op_addr[base + 2]}, {1'b1, 28'h0000050});

        // Asynchronous reset in the middle of a memory write.
        mem_stall = 1'b1;
        cache_wr(28'h0000070, rnd_line(), lat);
        repeat (2) step();
        chk("rst_pre_wr", mem_write, 1);
        wrc = n_wr_ops;
        #2 proc_reset_n = 1'b0;
        #1;
        chk("arst_mem_write", mem_write, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_mem_wdata", mem_wdata, 0);
        chk("arst_cache_ready", cache_ready, 0);
        chk("arst_wbuf_empty", wbuf_empty, 1);
        model_img.delete();
        foreach (mem_img[k]) model_img[k] = mem_img[k];
        mem_stall = 1'b0;
        mem_lat   = 1;
        repeat (2) @(posedge clk);
        #1 proc_reset_n = 1'b1;
        repeat (10) step();
        chk("arst_no_wr", n_wr_ops - wrc, 0);
        cache_rd(28'h0000070, rd, lat);
        chk("arst_read_back", rd, model_val(28'h0000070));

        // Random traffic on a small address pool to exercise hits, merges and full stalls.
        for (int it = 0; it < 300; it++) begin
            mem_lat = $urandom_range(0, 3);
            a = 28'h0000200 + 28'($urandom_range(0, 5));
            if ($urandom_range(0, 99) < 55) begin
                cache_wr(a, rnd_line(), lat);
            end else begin
                cache_rd(a, rd, lat);
                chk("rand_rd", rd, model_val(a));
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) step();
        end
        wait_empty("drain_rand");
        for (int i = 0; i < 6; i++) begin
            chk("final_img", mem_val(28'h0000200 + 28'(i)), model_val(28'h0000200 + 28'(i)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
